// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial interface controller.
// Covers the FSM state encoding, IMU command words and default calibration offsets.
package inert_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT,
    CFG,
    IDLE,
    RD_RL,
    RD_RH,
    RD_AZL,
    RD_AZH,
    COMPUTE,
    OUTPUT
  } inert_state_e;

  // IMU configuration writes, issued in index order after power-up
  localparam logic [15:0] CFG_CMD_0 = 16'h0D02;
  localparam logic [15:0] CFG_CMD_1 = 16'h1053;
  localparam logic [15:0] CFG_CMD_2 = 16'h1150;
  localparam logic [15:0] CFG_CMD_3 = 16'h1460;

  localparam logic [15:0] RD_RL_CMD  = 16'hA200;
  localparam logic [15:0] RD_RH_CMD  = 16'hA300;
  localparam logic [15:0] RD_AZL_CMD = 16'hAC00;
  localparam logic [15:0] RD_AZH_CMD = 16'hAD00;

  localparam logic [15:0] DEF_PTCH_RT_OFFSET = 16'h0050;
  localparam logic [15:0] DEF_AZ_OFFSET      = 16'h00A0;
  localparam int          DEF_FUSION_K       = 1024;

  function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CFG_CMD_0;
      2'd1:    return CFG_CMD_1;
      2'd2:    return CFG_CMD_2;
      default: return CFG_CMD_3;
    endcase
  endfunction

endpackage

// File: rtl/inert_integrator.sv
// Pitch integrator: removes the gyro offset, accumulates into 27 bits and publishes ptch.
// Define INERT_FUSION_EN to add the accelerometer-based correction step.
module inert_integrator
  import inert_pkg::*;
#(
  parameter logic [15:0] PTCH_RT_OFFSET = DEF_PTCH_RT_OFFSET,
  parameter logic [15:0] AZ_OFFSET      = DEF_AZ_OFFSET,
  parameter int          FUSION_K       = DEF_FUSION_K
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        publish,
  input  logic [15:0] rate,
`ifdef INERT_FUSION_EN
  input  logic [15:0] az,
`endif
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt
);

  logic [15:0]        rate_diff;
  logic signed [26:0] rate_term;
  logic signed [26:0] fusion;
  logic signed [26:0] integ;

  // Subtract in 16 bits so the difference wraps, then sign-extend
  assign rate_diff = rate - PTCH_RT_OFFSET;
  assign rate_term = {{11{rate_diff[15]}}, rate_diff};

`ifdef INERT_FUSION_EN
  logic [15:0]        az_diff;
  logic signed [31:0] az_ext;
  logic signed [31:0] acc_prod;
  logic signed [15:0] ptch_acc;

  assign az_diff  = az - AZ_OFFSET;
  assign az_ext   = {{16{az_diff[15]}}, az_diff};
  assign acc_prod = az_ext * 32'sd327;
  assign ptch_acc = acc_prod[28:13];
  assign fusion   = (ptch_acc > $signed(ptch)) ? 27'(FUSION_K) : -27'(FUSION_K);
`else
  logic unused_fusion_cfg;
  assign unused_fusion_cfg = ^{AZ_OFFSET, 32'(FUSION_K)};
  assign fusion = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ   <= '0;
      ptch    <= '0;
      ptch_rt <= '0;
    end else begin
      if (load) begin
        ptch_rt <= rate;
        integ   <= integ - rate_term + fusion;
      end
      if (publish) ptch <= integ[26:11];
    end
  end

endmodule

// File: rtl/inert_intf_ctrl.sv
// IMU sequencer: configures the IMU over SPI, reads rate/AZ on each INT and drives ptch/ptch_rt/vld.
// Define INERT_FUSION_EN to enable the accelerometer correction of the integrator.
module inert_intf_ctrl
  import inert_pkg::*;
#(
  parameter bit          FAST_SIM       = 1'b1,
  parameter logic [15:0] PTCH_RT_OFFSET = DEF_PTCH_RT_OFFSET,
  parameter logic [15:0] AZ_OFFSET      = DEF_AZ_OFFSET,
  parameter int          FUSION_K       = DEF_FUSION_K
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         INT,
  input  logic         done,
  input  logic [15:0]  rd_data,
  output logic         wrt,
  output logic [15:0]  cmd,
  output logic [15:0]  ptch,
  output logic [15:0]  ptch_rt,
  output logic         vld,
  output inert_state_e state_dbg
);

  localparam logic [15:0] TMR_TERM = FAST_SIM ? 16'd1023 : 16'hFFFF;

  // SPI handshake: wrt is a 1-clk start pulse with cmd valid; cmd stays put until the
  // master returns a 1-clk done. A done is accepted only while a transaction is outstanding.
  inert_state_e state, state_n;
  logic [15:0]  tmr;
  logic [1:0]   cfg_idx, cfg_idx_n;
  logic         wrt_n;
  logic [15:0]  cmd_n;
  logic         int_s1, int_s2, int_s3, int_rise;
  logic         done_ok, load;
  logic [7:0]   rate_l, rate_h;
  logic         unused_rd_hi;

  assign int_rise     = int_s2 & ~int_s3;
  assign done_ok      = done & ~wrt;
  assign state_dbg    = state;
  assign unused_rd_hi = ^rd_data[15:8];

  always_comb begin
    state_n   = state;
    cfg_idx_n = cfg_idx;
    wrt_n     = 1'b0;
    cmd_n     = cmd;
    load      = 1'b0;
    case (state)
      INIT_WAIT: if (tmr == TMR_TERM) begin
        state_n   = CFG;
        cfg_idx_n = 2'd0;
        wrt_n     = 1'b1;
        cmd_n     = cfg_cmd(2'd0);
      end
      CFG: if (done_ok) begin
        if (cfg_idx == 2'd3) begin
          state_n = IDLE;
        end else begin
          cfg_idx_n = cfg_idx + 2'd1;
          wrt_n     = 1'b1;
          cmd_n     = cfg_cmd(cfg_idx + 2'd1);
        end
      end
      IDLE: if (int_rise) begin
        state_n = RD_RL;
        wrt_n   = 1'b1;
        cmd_n   = RD_RL_CMD;
      end
      RD_RL: if (done_ok) begin
        state_n = RD_RH;
        wrt_n   = 1'b1;
        cmd_n   = RD_RH_CMD;
      end
      RD_RH: if (done_ok) begin
        state_n = RD_AZL;
        wrt_n   = 1'b1;
        cmd_n   = RD_AZL_CMD;
      end
      RD_AZL: if (done_ok) begin
        state_n = RD_AZH;
        wrt_n   = 1'b1;
        cmd_n   = RD_AZH_CMD;
      end
      RD_AZH:  if (done_ok) state_n = COMPUTE;
      COMPUTE: begin
        load    = 1'b1;
        state_n = OUTPUT;
      end
      OUTPUT:  state_n = IDLE;
      default: state_n = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT_WAIT;
      tmr     <= '0;
      cfg_idx <= '0;
      wrt     <= 1'b0;
      cmd     <= '0;
      vld     <= 1'b0;
      int_s1  <= 1'b0;
      int_s2  <= 1'b0;
      int_s3  <= 1'b0;
      rate_l  <= '0;
      rate_h  <= '0;
    end else begin
      state   <= state_n;
      cfg_idx <= cfg_idx_n;
      wrt     <= wrt_n;
      cmd     <= cmd_n;
      vld     <= (state == OUTPUT);
      int_s1  <= INT;
      int_s2  <= int_s1;
      int_s3  <= int_s2;
      tmr     <= (state == INIT_WAIT) ? tmr + 16'd1 : '0;
      if (done_ok && state == RD_RL) rate_l <= rd_data[7:0];
      if (done_ok && state == RD_RH) rate_h <= rd_data[7:0];
    end
  end

`ifdef INERT_FUSION_EN
  logic [7:0] az_l, az_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      az_l <= '0;
      az_h <= '0;
    end else begin
      if (done_ok && state == RD_AZL) az_l <= rd_data[7:0];
      if (done_ok && state == RD_AZH) az_h <= rd_data[7:0];
    end
  end
`endif

  // Integrator updates on COMPUTE; ptch and vld both change on the edge leaving OUTPUT
  inert_integrator #(
    .PTCH_RT_OFFSET(PTCH_RT_OFFSET),
    .AZ_OFFSET     (AZ_OFFSET),
    .FUSION_K      (FUSION_K)
  ) u_integ (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .publish(state == OUTPUT),
    .rate   ({rate_h, rate_l}),
`ifdef INERT_FUSION_EN
    .az     ({az_h, az_l}),
`endif
    .ptch   (ptch),
    .ptch_rt(ptch_rt)
  );

endmodule

// File: tb/tb_inert_intf_ctrl.sv
// Bench for inert_intf_ctrl: SPI slave model with command scoreboard, vector table and reset/INT corner cases.
// Builds with or without INERT_FUSION_EN; the fusion sequence runs only when it is defined.
module tb_inert_intf_ctrl;
  import inert_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         INT = 1'b0;
  logic         done = 1'b0;
  logic [15:0]  rd_data = '0;
  logic         wrt, vld;
  logic [15:0]  cmd, ptch, ptch_rt;
  inert_state_e state_dbg;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  inert_intf_ctrl #(.FAST_SIM(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .INT      (INT),
    .done     (done),
    .rd_data  (rd_data),
    .wrt      (wrt),
    .cmd      (cmd),
    .ptch     (ptch),
    .ptch_rt  (ptch_rt),
    .vld      (vld),
    .state_dbg(state_dbg)
  );

  typedef struct {
    logic [15:0] rate;
    logic [15:0] az;
    int          n;
    logic [15:0] exp_ptch;
    logic [15:0] exp_rt;
  } vec_t;

  logic [15:0] exp_q[$];
  int   cyc = 0;
  int   wrt_cnt = 0;
  int   rd_done_cnt = 0;
  int   vld_cnt = 0;
  int   first_wrt_cyc = -1;
  int   spi_cnt = 0;
  bit   spi_busy = 1'b0;
  bit   stray_req = 1'b0;
  logic [15:0] spi_cmd = '0;
  logic [7:0]  rate_lo = '0, rate_hi = '0, az_lo = '0, az_hi = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [15:0] spi_resp(input logic [15:0] c);
    case (c)
      16'hA200: return {8'hE5, rate_lo};
      16'hA300: return {8'h5E, rate_hi};
      16'hAC00: return {8'hC3, az_lo};
      16'hAD00: return {8'h3C, az_hi};
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else cyc++;
  end

  // SPI slave: done three negedges after a wrt is seen; every wrt is scored against exp_q
  always @(negedge clk) begin
    done = 1'b0;
    if (!rst_n) begin
      spi_busy = 1'b0;
    end else begin
      if (stray_req) begin
        done = 1'b1;
        stray_req = 1'b0;
      end else if (spi_busy) begin
        if (spi_cnt == 0) begin
          done = 1'b1;
          rd_data = spi_resp(spi_cmd);
          spi_busy = 1'b0;
          rd_done_cnt++;
        end else begin
          spi_cnt--;
        end
      end
      if (wrt) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_wrt: got cmd %h expected no transaction", cmd);
        end else begin
          check("spi_cmd", cmd, exp_q.pop_front());
        end
        if (wrt_cnt == 0) first_wrt_cyc = cyc;
        wrt_cnt++;
        spi_busy = 1'b1;
        spi_cnt = 2;
        spi_cmd = cmd;
      end
    end
    if (vld) vld_cnt++;
  end

  task automatic push_reads();
    exp_q.push_back(16'hA200);
    exp_q.push_back(16'hA300);
    exp_q.push_back(16'hAC00);
    exp_q.push_back(16'hAD00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    INT = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("rst_wrt", wrt, 0);
    check("rst_cmd", cmd, 0);
    check("rst_vld", vld, 0);
    check("rst_ptch", ptch, 0);
    check("rst_ptch_rt", ptch_rt, 0);
    check("rst_state", state_dbg, INIT_WAIT);
    wrt_cnt = 0;
    first_wrt_cyc = -1;
    exp_q.push_back(16'h0D02);
    exp_q.push_back(16'h1053);
    exp_q.push_back(16'h1150);
    exp_q.push_back(16'h1460);
    rst_n = 1'b1;
    for (int i = 0; i < 1400; i++) begin
      @(negedge clk);
      if (i == 5) stray_req = 1'b1;
      if (wrt_cnt == 4 && state_dbg == IDLE) break;
    end
    check("cfg_wrt_cnt", wrt_cnt, 4);
    check("cfg_idle", state_dbg, IDLE);
    check_range("init_wait", first_wrt_cyc, 1022, 1026);
    repeat (10) @(negedge clk);
    check("cfg_no_extra", wrt_cnt, 4);
  endtask

  task automatic run_sample(input bit chk_lat);
    int  t0;
    int  waited;
    bit  got;
    push_reads();
    INT = 1'b1;
    t0 = cyc;
    got = 1'b0;
    waited = 0;
    while (!got && waited < 200) begin
      @(negedge clk);
      waited++;
      if (waited == 3) INT = 1'b0;
      if (vld) got = 1'b1;
    end
    INT = 1'b0;
    check("vld_seen", got, 1);
    if (chk_lat) check("latency", cyc - t0, 21);
    @(negedge clk);
    check("vld_pulse", vld, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   base;
    vecs[0] = '{16'h0050, 16'h00A0, 4,  16'h0000, 16'h0050};
    vecs[1] = '{16'h0150, 16'h00A0, 8,  16'hFFFF, 16'h0150};
    vecs[2] = '{16'h0150, 16'h00A0, 16, 16'hFFFE, 16'h0150};
    vecs[3] = '{16'h0010, 16'h1234, 32, 16'h0001, 16'h0010};
    vecs[4] = '{16'h8050, 16'h00A0, 1,  16'h0010, 16'h8050};

    do_reset();

`ifndef INERT_FUSION_EN
    for (int v = 0; v < 5; v++) begin
      if (v != 0) do_reset();
      rate_lo = vecs[v].rate[7:0];
      rate_hi = vecs[v].rate[15:8];
      az_lo   = vecs[v].az[7:0];
      az_hi   = vecs[v].az[15:8];
      for (int s = 0; s < vecs[v].n; s++) begin
        run_sample(s == 0);
        if (v == 0) check("ptch_flat", ptch, 16'h0000);
      end
      check($sformatf("ptch_v%0d", v), ptch, vecs[v].exp_ptch);
      check($sformatf("ptch_rt_v%0d", v), ptch_rt, vecs[v].exp_rt);
    end
`else
    rate_lo = 8'h50;
    rate_hi = 8'h00;
    az_lo   = 8'hA0;
    az_hi   = 8'h20;
    for (int s = 1; s <= 8; s++) begin
      run_sample(s == 1);
      check($sformatf("fusion_ptch_s%0d", s), ptch, 16'(s >> 1));
    end
`endif

    // Stray done while idle must not start anything
    base = wrt_cnt;
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_idle_state", state_dbg, IDLE);
    check("stray_idle_wrt", wrt_cnt - base, 0);

    // Second INT edge during a burst is dropped
    rate_lo = 8'h50;
    rate_hi = 8'h01;
    az_lo   = 8'hA0;
    az_hi   = 8'h00;
    base = vld_cnt;
    push_reads();
    INT = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (i == 2) INT = 1'b0;
      if (i == 8) INT = 1'b1;
      if (i == 11) INT = 1'b0;
    end
    check("burst_int_vld_cnt", vld_cnt - base, 1);
    check("burst_int_state", state_dbg, IDLE);
    check("pre_rst_rt", ptch_rt, 16'h0150);

    // Reset between the 2nd and 3rd read done
    base = rd_done_cnt;
    push_reads();
    INT = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 2) INT = 1'b0;
      if (rd_done_cnt - base >= 2) break;
    end
    check("mid_two_done", rd_done_cnt - base, 2);
    do_reset();
    check("post_rst_rt", ptch_rt, 16'h0000);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
